// File: rtl/axis_pkg.sv
// Shared stream-side types and defaults for the send path (arbiter, skid, stream buffer).
package axis_pkg;
  localparam int AXIS_DATA_W    = 512;
  localparam int AXIS_DEST_W    = 5;
  localparam int AXIS_MAX_BURST = 64;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_DEST_W-1:0] dest;
    logic                   last;
  } axis_beat_t;

  typedef enum logic {IDLE, LOCK} arb_state_t;

  // Index width that stays at least 1 bit for degenerate counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axis_src_arb_if.sv
// Source-side fan-in and merged output stream of the source arbiter.
interface axis_src_arb_if
  import axis_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int DATA_W = AXIS_DATA_W,
  parameter int DEST_W = AXIS_DEST_W
);
  logic [N_IN-1:0]        in_tvalid;
  logic [N_IN-1:0]        in_tready;
  logic [N_IN*DATA_W-1:0] in_tdata;
  logic [N_IN*DEST_W-1:0] in_tdest;
  logic [N_IN-1:0]        in_tlast;
  logic                   out_tvalid;
  logic                   out_tready;
  logic [DATA_W-1:0]      out_tdata;
  logic [DEST_W-1:0]      out_tdest;
  logic                   out_tlast;

  modport master (
    output in_tvalid, in_tdata, in_tdest, in_tlast, out_tready,
    input  in_tready, out_tvalid, out_tdata, out_tdest, out_tlast
  );
  modport slave (
    input  in_tvalid, in_tdata, in_tdest, in_tlast, out_tready,
    output in_tready, out_tvalid, out_tdata, out_tdest, out_tlast
  );
endinterface

// File: rtl/axis_skid_buf.sv
// Generic 2-entry registered skid; ent0 is always the head and drives the output.
module axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         ready,
  output logic         valid,
  input  logic         out_ready,
  output logic [W-1:0] dout
);
  logic [W-1:0] ent0, ent1;
  logic [1:0]   cnt;
  logic         pop;

  assign pop   = valid && out_ready;
  assign ready = (cnt != 2'd2);
  assign valid = (cnt != 2'd0);
  assign dout  = ent0;

  // Callers push only while ready, so push into a full buffer never happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= din;
          else             ent1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= din;
          end else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/axis_src_arb.sv
// Round-robin merge of N_IN AXI-Stream sources with per-packet grant lock and
// a registered skid on the output.
module axis_src_arb
  import axis_pkg::*;
#(
  parameter  int N_IN      = 4,
  parameter  int DATA_W    = AXIS_DATA_W,
  parameter  int DEST_W    = AXIS_DEST_W,
  parameter  int MAX_BURST = AXIS_MAX_BURST,
  localparam int IDX_W     = idx_w(N_IN),
  localparam int CNT_W     = idx_w(MAX_BURST)
) (
  input  logic             clk,
  input  logic             rst,
  axis_src_arb_if.slave    bus,
  output logic             grant_busy,
  output logic [IDX_W-1:0] grant_idx
);
  localparam int BEAT_W = DATA_W + DEST_W + 1;

  arb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  sel, sel_nxt, rr_ptr, rr_nxt, cand;
  logic [IDX_W:0]    sum;
  logic [CNT_W-1:0]  beat_cnt, cnt_nxt;
  logic              found, acc, skid_rdy;
  logic [BEAT_W-1:0] beat_in, beat_out;
  int                base_d, base_t;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sel_nxt       = sel;
    rr_nxt        = rr_ptr;
    cnt_nxt       = beat_cnt;
    bus.in_tready = '0;
    acc           = 1'b0;
    found         = 1'b0;
    sum           = '0;
    cand          = '0;
    unique case (state)
      IDLE: begin
        // Scan from rr_ptr with an explicit wrap so non-power-of-two N_IN works.
        for (int k = 0; k < N_IN; k++) begin
          sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
          if (sum >= (IDX_W+1)'(N_IN)) sum = sum - (IDX_W+1)'(N_IN);
          cand = sum[IDX_W-1:0];
          if (!found && bus.in_tvalid[cand]) begin
            found   = 1'b1;
            sel_nxt = cand;
          end
        end
        if (found) begin
          state_nxt = LOCK;
          cnt_nxt   = '0;
        end
      end
      LOCK: begin
        bus.in_tready[sel] = skid_rdy;
        acc = bus.in_tvalid[sel] && skid_rdy;
        if (acc) begin
          cnt_nxt = beat_cnt + CNT_W'(1);
          if (bus.in_tlast[sel] || beat_cnt == CNT_W'(MAX_BURST-1)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            rr_nxt    = (sel == IDX_W'(N_IN-1)) ? '0 : sel + IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign base_d  = int'(sel) * DATA_W;
  assign base_t  = int'(sel) * DEST_W;
  assign beat_in = {bus.in_tdata[base_d +: DATA_W], bus.in_tdest[base_t +: DEST_W],
                    bus.in_tlast[sel]};

  axis_skid_buf #(.W(BEAT_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (acc),
    .din       (beat_in),
    .ready     (skid_rdy),
    .valid     (bus.out_tvalid),
    .out_ready (bus.out_tready),
    .dout      (beat_out)
  );

  assign {bus.out_tdata, bus.out_tdest, bus.out_tlast} = beat_out;
  assign grant_busy = (state == LOCK);
  assign grant_idx  = sel;
endmodule

// File: tb/tb_axis_src_arb.sv
// Directed bench for axis_src_arb: queued sources, output recorder, per-scenario checks.
module tb_axis_src_arb;
  import axis_pkg::*;

  localparam int N   = 4;
  localparam int DW  = AXIS_DATA_W;
  localparam int DSW = AXIS_DEST_W;
  localparam int MB  = AXIS_MAX_BURST;

  logic       clk = 1'b0;
  logic       rst;
  logic       grant_busy;
  logic [1:0] grant_idx;

  axis_src_arb_if #(.N_IN(N), .DATA_W(DW), .DEST_W(DSW)) bus ();

  axis_src_arb #(.N_IN(N), .DATA_W(DW), .DEST_W(DSW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .grant_busy (grant_busy),
    .grant_idx  (grant_idx)
  );

  always #5 clk = ~clk;

  axis_beat_t src_q[N][$];
  axis_beat_t obs[$];
  axis_beat_t exp_q[$];
  axis_beat_t stall_beat;
  logic [N-1:0] src_en;
  logic prev_stall;
  int rdy_mode, ph, cyc, checks, failures;
  int iv_cyc, ov_cyc, stall_err, stall_cnt;

  function automatic axis_beat_t mk(input int s, input int i, input int d, input bit l);
    axis_beat_t b;
    b.data = DW'({8'(s), 8'hA5, 16'(i)});
    b.dest = DSW'(d);
    b.last = l;
    return b;
  endfunction

  // One clock: drive at edge+1, sample at negedge, retire handshakes at next edge+1.
  task automatic step();
    logic [N-1:0] hs;
    axis_beat_t cur;
    for (int i = 0; i < N; i++) begin
      if (src_en[i] && src_q[i].size() > 0) begin
        bus.in_tvalid[i]            = 1'b1;
        bus.in_tdata[i*DW +: DW]    = src_q[i][0].data;
        bus.in_tdest[i*DSW +: DSW]  = src_q[i][0].dest;
        bus.in_tlast[i]             = src_q[i][0].last;
      end else begin
        bus.in_tvalid[i] = 1'b0;
      end
    end
    case (rdy_mode)
      0:       bus.out_tready = 1'b0;
      1:       bus.out_tready = 1'b1;
      default: bus.out_tready = (ph % 4 == 0) || (ph % 4 == 3);
    endcase
    ph++;
    @(negedge clk);
    hs  = bus.in_tvalid & bus.in_tready;
    cur = {bus.out_tdata, bus.out_tdest, bus.out_tlast};
    if (iv_cyc < 0 && |bus.in_tvalid) iv_cyc = cyc;
    if (ov_cyc < 0 && bus.out_tvalid) ov_cyc = cyc;
    if (prev_stall) begin
      stall_cnt++;
      if (!bus.out_tvalid || cur !== stall_beat) stall_err++;
    end
    prev_stall = !rst && bus.out_tvalid && !bus.out_tready;
    stall_beat = cur;
    if (!rst && bus.out_tvalid && bus.out_tready) obs.push_back(cur);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++)
      if (hs[i] && !rst) void'(src_q[i].pop_front());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    src_en   = '1;
    rdy_mode = 1;
    step();
    step();
    rst = 1'b0;
    obs.delete();
    exp_q.delete();
    iv_cyc = -1; ov_cyc = -1;
    stall_err = 0; stall_cnt = 0; prev_stall = 1'b0;
  endtask

  task automatic run_obs(input int n, input int budget, output bit ok);
    int b = budget;
    while (obs.size() < n && b > 0) begin
      step();
      b--;
    end
    ok = (obs.size() >= n);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_tvalid !== 1'b0) begin failures++; $display("FAIL reset out_tvalid got=%b exp=0", bus.out_tvalid); end
    checks++; if (bus.in_tready !== 4'b0) begin failures++; $display("FAIL reset in_tready got=%b exp=0000", bus.in_tready); end
    checks++; if (grant_busy !== 1'b0) begin failures++; $display("FAIL reset grant_busy got=%b exp=0", grant_busy); end
    checks++; if (grant_idx !== 2'd0) begin failures++; $display("FAIL reset grant_idx got=%0d exp=0", grant_idx); end
    step();
    checks++; if (grant_busy !== 1'b0) begin failures++; $display("FAIL reset idle_busy got=%b exp=0", grant_busy); end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    exp_q.push_back(mk(0, 0, 7, 0));
    exp_q.push_back(mk(0, 1, 7, 0));
    exp_q.push_back(mk(0, 2, 7, 1));
    src_q[0] = exp_q;
    run_obs(3, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single timeout got=%0d beats exp=3", obs.size()); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= obs.size() || obs[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL single beat%0d got=%h/%0d/%b exp=%h/%0d/%b", k,
                 (k < obs.size()) ? obs[k].data[31:0] : 32'hx, (k < obs.size()) ? obs[k].dest : 5'hx,
                 (k < obs.size()) ? obs[k].last : 1'bx, exp_q[k].data[31:0], exp_q[k].dest, exp_q[k].last);
      end
    end
    checks++; if (ov_cyc - iv_cyc !== 2) begin failures++; $display("FAIL single latency got=%0d exp=2", ov_cyc - iv_cyc); end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    src_q[1].push_back(mk(1, 0, 1, 0)); src_q[1].push_back(mk(1, 1, 1, 1));
    src_q[3].push_back(mk(3, 0, 3, 0)); src_q[3].push_back(mk(3, 1, 3, 1));
    exp_q = {src_q[1], src_q[3]};
    run_obs(4, 60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr1 timeout got=%0d beats exp=4", obs.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= obs.size() || obs[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL rr1 beat%0d got=%h exp=%h", k, (k < obs.size()) ? obs[k].data[31:0] : 32'hx, exp_q[k].data[31:0]);
      end
    end
    obs.delete();
    src_q[0].push_back(mk(0, 0, 2, 0)); src_q[0].push_back(mk(0, 1, 2, 1));
    src_q[1].push_back(mk(1, 2, 4, 0)); src_q[1].push_back(mk(1, 3, 4, 1));
    exp_q = {src_q[0], src_q[1]};
    run_obs(4, 60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr2 timeout got=%0d beats exp=4", obs.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= obs.size() || obs[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL rr2 beat%0d got=%h exp=%h", k, (k < obs.size()) ? obs[k].data[31:0] : 32'hx, exp_q[k].data[31:0]);
      end
    end
  endtask

  task automatic test_burst_cap();
    int gaps = 0, b = 300, bad = 0;
    bit seen = 0;
    do_reset();
    for (int k = 0; k < 70; k++) exp_q.push_back(mk(2, k, 2, k == 69));
    src_q[2] = exp_q;
    while (obs.size() < 70 && b > 0) begin
      step();
      b--;
      if (seen && src_q[2].size() > 0 && !grant_busy) gaps++;
      if (grant_busy) begin
        seen = 1;
        if (grant_idx !== 2'd2) bad++;
      end
    end
    checks++; if (obs.size() !== 70) begin failures++; $display("FAIL burst count got=%0d exp=70", obs.size()); end
    for (int k = 0; k < 70; k++) begin
      checks++;
      if (k >= obs.size() || obs[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL burst beat%0d got=%h/%b exp=%h/%b", k, (k < obs.size()) ? obs[k].data[31:0] : 32'hx,
                 (k < obs.size()) ? obs[k].last : 1'bx, exp_q[k].data[31:0], exp_q[k].last);
      end
    end
    checks++; if (gaps !== 1) begin failures++; $display("FAIL burst release_gap got=%0d exp=1", gaps); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL burst grant_idx wrong_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_backpressure();
    int gaps = 0, b = 120;
    bit seen = 0;
    do_reset();
    rdy_mode = 2;
    ph = 0;
    for (int k = 0; k < 10; k++) exp_q.push_back(mk(0, k, k + 3, k == 9));
    src_q[0] = exp_q;
    while (obs.size() < 10 && b > 0) begin
      step();
      b--;
      if (seen && src_q[0].size() > 0 && !grant_busy) gaps++;
      if (grant_busy) seen = 1;
    end
    checks++; if (obs.size() !== 10) begin failures++; $display("FAIL bp count got=%0d exp=10", obs.size()); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (k >= obs.size() || obs[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL bp beat%0d got=%h/%0d exp=%h/%0d", k, (k < obs.size()) ? obs[k].data[31:0] : 32'hx,
                 (k < obs.size()) ? obs[k].dest : 5'hx, exp_q[k].data[31:0], exp_q[k].dest);
      end
    end
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL bp stability got=%0d unstable exp=0", stall_err); end
    checks++; if (stall_cnt < 1) begin failures++; $display("FAIL bp stalls got=%0d exp>=1", stall_cnt); end
    checks++; if (gaps !== 0) begin failures++; $display("FAIL bp dest_release got=%0d exp=0", gaps); end
  endtask

  task automatic test_idle_locked();
    int b = 20, tr1 = 0, nb = 0, gi = 0;
    bit ok;
    do_reset();
    src_q[0].push_back(mk(0, 0, 4, 0)); src_q[0].push_back(mk(0, 1, 4, 1));
    src_q[1].push_back(mk(1, 0, 9, 1));
    exp_q = {src_q[0], src_q[1]};
    while (src_q[0].size() > 1 && b > 0) begin step(); b--; end
    checks++; if (src_q[0].size() !== 1) begin failures++; $display("FAIL idle first_beat left=%0d exp=1", src_q[0].size()); end
    src_en[0] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.in_tready[1]) tr1++;
      if (!grant_busy) nb++;
      if (grant_idx !== 2'd0) gi++;
    end
    checks++; if (tr1 !== 0) begin failures++; $display("FAIL idle src1_ready got=%0d cycles exp=0", tr1); end
    checks++; if (nb !== 0) begin failures++; $display("FAIL idle busy_drop got=%0d cycles exp=0", nb); end
    checks++; if (gi !== 0) begin failures++; $display("FAIL idle grant_idx got=%0d bad cycles exp=0", gi); end
    src_en[0] = 1'b1;
    run_obs(3, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL idle timeout got=%0d beats exp=3", obs.size()); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= obs.size() || obs[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL idle beat%0d got=%h exp=%h", k, (k < obs.size()) ? obs[k].data[31:0] : 32'hx, exp_q[k].data[31:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int b = 20;
    bit ok;
    do_reset();
    for (int k = 0; k < 10; k++) src_q[3].push_back(mk(3, k, 5, k == 9));
    run_obs(3, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid pre timeout got=%0d beats exp=3", obs.size()); end
    rdy_mode = 0;
    do begin step(); b--; end
    while (!(grant_busy && bus.out_tvalid && bus.in_tready == 4'b0) && b > 0);
    checks++; if (b <= 0) begin failures++; $display("FAIL rstmid skid_full not reached got=%b exp=0000", bus.in_tready); end
    src_q[1].push_back(mk(1, 0, 6, 0)); src_q[1].push_back(mk(1, 1, 6, 1));
    exp_q = src_q[1];
    rst = 1'b1;
    step();
    rst = 1'b0;
    obs.delete();
    checks++; if (bus.out_tvalid !== 1'b0) begin failures++; $display("FAIL rstmid out_tvalid got=%b exp=0", bus.out_tvalid); end
    checks++; if (bus.in_tready !== 4'b0) begin failures++; $display("FAIL rstmid in_tready got=%b exp=0000", bus.in_tready); end
    checks++; if (grant_busy !== 1'b0) begin failures++; $display("FAIL rstmid grant_busy got=%b exp=0", grant_busy); end
    step();
    checks++; if (grant_busy !== 1'b1) begin failures++; $display("FAIL rstmid regrant_busy got=%b exp=1", grant_busy); end
    checks++; if (grant_idx !== 2'd1) begin failures++; $display("FAIL rstmid regrant_idx got=%0d exp=1", grant_idx); end
    checks++; if (bus.out_tvalid !== 1'b0) begin failures++; $display("FAIL rstmid stale_beat got=%b exp=0", bus.out_tvalid); end
    rdy_mode = 1;
    run_obs(2, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid post timeout got=%0d beats exp=2", obs.size()); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (k >= obs.size() || obs[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL rstmid beat%0d got=%h exp=%h", k, (k < obs.size()) ? obs[k].data[31:0] : 32'hx, exp_q[k].data[31:0]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; ph = 0;
    rst = 1'b1;
    rdy_mode = 1;
    src_en = '1;
    prev_stall = 1'b0;
    stall_err = 0; stall_cnt = 0;
    iv_cyc = -1; ov_cyc = -1;
    bus.in_tvalid  = '0;
    bus.in_tdata   = '0;
    bus.in_tdest   = '0;
    bus.in_tlast   = '0;
    bus.out_tready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_idle_locked();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
